// File: rtl/aes_shiftrows_pipe.sv
// aes_shiftrows_pipe: AES ShiftRows / InvShiftRows across LANES 128-bit states
// per beat, followed by a DEPTH-entry valid/ready output FIFO with tag sideband.
// Optional feature macro: SHIFTROWS_BYPASS_EN (adds in_bypass to store beats untransformed).
module aes_shiftrows_pipe #(
  parameter int unsigned LANES = 1,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_inv,
`ifdef SHIFTROWS_BYPASS_EN
  input  logic                     in_bypass,
`endif
  input  logic [TAG_W-1:0]         in_tag,
  input  logic [128*LANES-1:0]     in_state,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [TAG_W-1:0]         out_tag,
  output logic [128*LANES-1:0]     out_state,
  output logic [$clog2(DEPTH):0]   fill
);

  localparam int unsigned W      = 128 * LANES;
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned FILL_W = PTR_W + 1;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [W-1:0]     state;
  } entry_t;

  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [PTR_W-1:0]   wr_ptr_nxt, rd_ptr_nxt;
  logic [FILL_W-1:0]  fill_nxt;
  logic               push, pop;
  logic [W-1:0]       shifted;
  entry_t             wr_entry;
  entry_t             head_nxt;

  // Source column of output byte (r,c): rotate row r left (forward) or right (inverse) by r.
  function automatic int unsigned src_col(input int unsigned r, input int unsigned c,
                                          input logic inv);
    src_col = inv ? ((c + 4 - r) % 4) : ((c + r) % 4);
  endfunction

  // Byte permutation, identical for every lane of the beat.
  always_comb begin
    shifted = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      for (int unsigned c = 0; c < 4; c++) begin
        for (int unsigned r = 0; r < 4; r++) begin
          shifted[128*k + 8*(r + 4*c) +: 8] =
            in_state[128*k + 8*(r + 4*src_col(r, c, in_inv)) +: 8];
        end
      end
    end
  end

  // Entry written on push: transformed (or raw, when bypassed) state plus tag.
  always_comb begin
    wr_entry.tag   = in_tag;
    wr_entry.state = shifted;
`ifdef SHIFTROWS_BYPASS_EN
    if (in_bypass) begin
      wr_entry.state = in_state;
    end
`endif
  end

  // Handshake decode and next pointer/occupancy; head register reload value.
  always_comb begin
    push       = in_valid & in_ready & ~rst;
    pop        = out_valid & out_ready;
    wr_ptr_nxt = wr_ptr + PTR_W'(push);
    rd_ptr_nxt = rd_ptr + PTR_W'(pop);
    fill_nxt   = fill + FILL_W'(push) - FILL_W'(pop);
    head_nxt   = mem[rd_ptr_nxt];
    // A beat written this cycle into the slot that becomes the head must be forwarded.
    if (push && (rd_ptr_nxt == wr_ptr)) begin
      head_nxt = wr_entry;
    end
  end

  // FIFO storage; deliberately not cleared by reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_entry;
    end
  end

  // Pointers, occupancy, flags and registered head outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fill      <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      out_tag   <= '0;
      out_state <= '0;
    end else begin
      wr_ptr    <= wr_ptr_nxt;
      rd_ptr    <= rd_ptr_nxt;
      fill      <= fill_nxt;
      out_valid <= (fill_nxt != '0);
      in_ready  <= (fill_nxt < FILL_W'(DEPTH));
      // Head holds its last value while empty so stale storage never shows.
      if (fill_nxt != '0) begin
        out_tag   <= head_nxt.tag;
        out_state <= head_nxt.state;
      end
    end
  end

endmodule

// File: tb/tb_aes_shiftrows_pipe.sv
// Self-checking bench for aes_shiftrows_pipe (LANES=2, DEPTH=4): directed cases
// followed by random traffic, checked against a row-rotation reference model.
module tb_aes_shiftrows_pipe;

  localparam int unsigned LANES = 2;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned TAG_W = 8;
  localparam int unsigned W     = 128 * LANES;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   in_valid;
  logic                   in_ready;
  logic                   in_inv;
`ifdef SHIFTROWS_BYPASS_EN
  logic                   in_bypass;
`endif
  logic [TAG_W-1:0]       in_tag;
  logic [W-1:0]           in_state;
  logic                   out_valid;
  logic                   out_ready;
  logic [TAG_W-1:0]       out_tag;
  logic [W-1:0]           out_state;
  logic [$clog2(DEPTH):0] fill;

  int n_vec = 0;
  int n_err = 0;
  bit started = 0;
  logic [TAG_W+W-1:0] sb[$];

  aes_shiftrows_pipe #(.LANES(LANES), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_inv    (in_inv),
`ifdef SHIFTROWS_BYPASS_EN
    .in_bypass (in_bypass),
`endif
    .in_tag    (in_tag),
    .in_state  (in_state),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_tag   (out_tag),
    .out_state (out_state),
    .fill      (fill)
  );

  always #5 clk = ~clk;

  // Reference: load each row into a queue and rotate it r places.
  function automatic logic [127:0] ref_sr(input logic [127:0] s, input bit inv);
    logic [7:0] row[$];
    logic [127:0] o;
    o = '0;
    for (int r = 0; r < 4; r++) begin
      row.delete();
      for (int c = 0; c < 4; c++) row.push_back(s[8*(r+4*c) +: 8]);
      for (int n = 0; n < r; n++) begin
        if (!inv) row.push_back(row.pop_front());
        else      row.push_front(row.pop_back());
      end
      for (int c = 0; c < 4; c++) o[8*(r+4*c) +: 8] = row[c];
    end
    return o;
  endfunction

  function automatic logic [W-1:0] ref_beat(input logic [W-1:0] s, input bit inv, input bit byp);
    logic [W-1:0] o;
    for (int k = 0; k < LANES; k++) o[128*k +: 128] = byp ? s[128*k +: 128] : ref_sr(s[128*k +: 128], inv);
    return o;
  endfunction

  task automatic chk(input string tag, input logic [W+TAG_W-1:0] obs, input logic [W+TAG_W-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rand_state();
    for (int i = 0; i < W/32; i++) in_state[32*i +: 32] = $urandom;
  endtask

  // One clock: check visible outputs against the model, advance the model, step.
  task automatic cycle();
    bit push, pop, byp;
    logic [TAG_W+W-1:0] head;
    if (started) begin
      chk("fill", fill, sb.size());
      chk("out_valid", out_valid, (sb.size() != 0));
      chk("in_ready", in_ready, (sb.size() < DEPTH));
      if (sb.size() != 0) begin
        head = sb[0];
        chk("out_tag", out_tag, head[TAG_W+W-1:W]);
        chk("out_state", out_state, head[W-1:0]);
      end
    end
    byp = 0;
`ifdef SHIFTROWS_BYPASS_EN
    byp = in_bypass;
`endif
    push = in_valid && (sb.size() < DEPTH) && !rst;
    pop  = (sb.size() != 0) && out_ready;
    if (rst) sb.delete();
    else begin
      if (pop)  void'(sb.pop_front());
      if (push) sb.push_back({in_tag, ref_beat(in_state, in_inv, byp)});
    end
    @(posedge clk);
    #1;
  endtask

  logic [127:0] vec_in, vec_fwd;

  initial begin
    vec_in  = 128'h0f0e0d0c0b0a09080706050403020100;
    vec_fwd = 128'h0b06010c07020d08030e09040f0a0500;
    rst = 1; in_valid = 0; in_inv = 0; in_tag = '0; in_state = '0; out_ready = 0;
`ifdef SHIFTROWS_BYPASS_EN
    in_bypass = 0;
`endif
    #1;
    cycle();
    cycle();
    rst = 0;
    started = 1;
    chk("rst_fill", fill, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_state", out_state, 0);
    chk("rst_out_tag", out_tag, 0);

    // Forward known vector in lane 0, random lane 1.
    rand_state();
    in_state[127:0] = vec_in;
    in_valid = 1; in_inv = 0; in_tag = 8'hA5;
    cycle();
    in_valid = 0;
    chk("fwd_latency_valid", out_valid, 1);
    chk("fwd_vector", out_state[127:0], vec_fwd);
    chk("fwd_tag", out_tag, 8'hA5);

    // Inverse round trip while the forward result pops.
    rand_state();
    in_state[127:0] = vec_fwd;
    in_valid = 1; in_inv = 1; in_tag = 8'h3C; out_ready = 1;
    cycle();
    in_valid = 0;
    chk("inv_vector", out_state[127:0], vec_in);
    chk("inv_tag", out_tag, 8'h3C);
    cycle();
    cycle();

    // Back-pressure: five beats offered, only four fit.
    out_ready = 0;
    for (int t = 1; t <= 5; t++) begin
      in_valid = 1; in_inv = 1'($urandom_range(0, 1)); in_tag = TAG_W'(t); rand_state();
      cycle();
    end
    chk("bp_in_ready", in_ready, 0);
    chk("bp_fill", fill, 4);
    // Pop at full with a pending push: push is blocked this cycle.
    out_ready = 1;
    cycle();
    chk("full_pushpop_fill", fill, 3);
    cycle();
    chk("pushpop_fill", fill, 3);
    in_valid = 0;
    for (int i = 0; i < 4; i++) cycle();
    chk("drain_empty", out_valid, 0);

    // Mid-stream reset with three beats buffered.
    out_ready = 0;
    for (int t = 0; t < 3; t++) begin
      in_valid = 1; in_inv = 0; in_tag = TAG_W'(8'h40 + t); rand_state();
      cycle();
    end
    chk("pre_rst_fill", fill, 3);
    rst = 1;
    in_tag = 8'h77;
    cycle();
    rst = 0; in_valid = 0;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_fill", fill, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_out_state", out_state, 0);
    out_ready = 1;
    cycle();
    cycle();
    in_valid = 1; in_inv = 0; in_tag = 8'h99; rand_state();
    cycle();
    in_valid = 0;
    chk("post_rst_tag", out_tag, 8'h99);
    cycle();

    // Random traffic with random direction and back-pressure.
    for (int i = 0; i < 400; i++) begin
      in_valid  = 1'($urandom_range(0, 3) != 0);
      out_ready = 1'($urandom_range(0, 2) != 0);
      in_inv    = 1'($urandom_range(0, 1));
      in_tag    = TAG_W'($urandom);
      rand_state();
      cycle();
    end

`ifdef SHIFTROWS_BYPASS_EN
    // Bypassed beats are stored as presented.
    in_valid = 0; out_ready = 1;
    for (int i = 0; i < 6; i++) cycle();
    in_valid = 1; in_bypass = 1; in_inv = 1; in_tag = 8'h5A; rand_state();
    cycle();
    chk("bypass_state", out_state, in_state);
    in_valid = 0; in_bypass = 0;
`endif

    in_valid = 0; out_ready = 1;
    for (int i = 0; i < 8; i++) cycle();
    chk("final_empty", out_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
